match_controller: RTL and testbench

//  Parametrised two-innings cricket match controller: accumulates runs/wickets/balls per delivery for the batting team,

---
 rtl/match_pkg.sv | 17 +
 rtl/innings_counter.sv | 44 ++++
 rtl/match_controller.sv | 146 ++++++++++++++
 tb/tb_match_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg: shared state encoding and winner codes for the match controller.
package match_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INN1     = 3'd1,
    S_BREAK    = 3'd2,
    S_INN2     = 3'd3,
    S_DONE     = 3'd4,
    S_SO1      = 3'd5,
    S_SO_BREAK = 3'd6,
    S_SO2      = 3'd7
  } state_t;
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_T1   = 2'd1;
  localparam logic [1:0] WIN_T2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;
endpackage

// File: rtl/innings_counter.sv
// innings_counter: per-inning runs/wickets/balls accumulator with saturating runs and limit detection.
module innings_counter #(
  parameter int RUN_W  = 8,
  parameter int BALL_W = 7,
  parameter int WKT_W  = 4
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              clear,
  input  logic              ball,
  input  logic [2:0]        runs_in,
  input  logic              legal_ball,
  input  logic              wicket_in,
  input  logic [BALL_W-1:0] max_balls,
  input  logic [WKT_W-1:0]  max_wkts,
  output logic [RUN_W-1:0]  runs,
  output logic [RUN_W-1:0]  runs_nxt,
  output logic [WKT_W-1:0]  wkts,
  output logic [BALL_W-1:0] balls,
  output logic              limit_hit
);
  logic [RUN_W:0]  sum;
  logic [WKT_W-1:0]  wkts_nxt;
  logic [BALL_W-1:0] balls_nxt;
  // Next values assume this delivery is taken; the FSM decides inning end from them.
  always_comb begin
    sum       = {1'b0, runs} + (RUN_W+1)'(runs_in);
    runs_nxt  = sum[RUN_W] ? '1 : sum[RUN_W-1:0];
    wkts_nxt  = wkts + WKT_W'(wicket_in);
    balls_nxt = balls + BALL_W'(legal_ball);
    limit_hit = (wkts_nxt == max_wkts) || (balls_nxt == max_balls);
  end
  always_ff @(posedge clk_fpga) begin
    if (reset || clear) begin
      runs  <= '0;
      wkts  <= '0;
      balls <= '0;
    end else if (ball) begin
      runs  <= runs_nxt;
      wkts  <= wkts_nxt;
      balls <= balls_nxt;
    end
  end
endmodule

// File: rtl/match_controller.sv
// match_controller: two-innings cricket match FSM; define SUPER_OVER_EN for a super-over tie-break.
module match_controller
  import match_pkg::*;
#(
  parameter int MAX_BALLS = 120,
  parameter int MAX_WKTS  = 10,
  parameter int RUN_W     = 8,
  parameter int BALL_W    = 7,
  parameter int WKT_W     = 4
`ifdef SUPER_OVER_EN
  ,
  parameter int SO_BALLS  = 6,
  parameter int SO_WKTS   = 2
`endif
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              start,
  input  logic              ball_valid,
  input  logic [2:0]        runs_in,
  input  logic              legal_ball,
  input  logic              wicket_in,
  output logic              batting_team,
  output logic [RUN_W-1:0]  team1_runs,
  output logic [RUN_W-1:0]  team2_runs,
  output logic [WKT_W-1:0]  team1_wkts,
  output logic [WKT_W-1:0]  team2_wkts,
  output logic [BALL_W-1:0] team1_balls,
  output logic [BALL_W-1:0] team2_balls,
  output logic [RUN_W:0]    target,
  output logic              inning_over,
  output logic              game_over,
  output logic [1:0]        winner
`ifdef SUPER_OVER_EN
  ,
  output logic [RUN_W-1:0]  so_runs1,
  output logic [RUN_W-1:0]  so_runs2
`endif
);
  state_t state;
  logic [RUN_W-1:0] r1_nxt, r2_nxt;
  logic lim1, lim2, clr;
  assign clr = (state == S_IDLE) && start;
  innings_counter #(.RUN_W(RUN_W), .BALL_W(BALL_W), .WKT_W(WKT_W)) u_team1 (
    .clk_fpga, .reset, .clear(clr), .ball(ball_valid && state == S_INN1),
    .runs_in, .legal_ball, .wicket_in,
    .max_balls(BALL_W'(MAX_BALLS)), .max_wkts(WKT_W'(MAX_WKTS)),
    .runs(team1_runs), .runs_nxt(r1_nxt), .wkts(team1_wkts), .balls(team1_balls), .limit_hit(lim1)
  );
  innings_counter #(.RUN_W(RUN_W), .BALL_W(BALL_W), .WKT_W(WKT_W)) u_team2 (
    .clk_fpga, .reset, .clear(clr), .ball(ball_valid && state == S_INN2),
    .runs_in, .legal_ball, .wicket_in,
    .max_balls(BALL_W'(MAX_BALLS)), .max_wkts(WKT_W'(MAX_WKTS)),
    .runs(team2_runs), .runs_nxt(r2_nxt), .wkts(team2_wkts), .balls(team2_balls), .limit_hit(lim2)
  );
`ifdef SUPER_OVER_EN
  logic [RUN_W-1:0]  so_cur, so_nxt;
  logic [WKT_W-1:0]  so_wkts;
  logic [BALL_W-1:0] so_balls;
  logic [RUN_W:0]    so_target;
  logic              so_lim;
  // One super-over counter serves both sides; it is cleared again when team 2 starts its over.
  innings_counter #(.RUN_W(RUN_W), .BALL_W(BALL_W), .WKT_W(WKT_W)) u_so (
    .clk_fpga, .reset, .clear(clr || (state == S_SO_BREAK && start)),
    .ball(ball_valid && (state == S_SO1 || state == S_SO2)),
    .runs_in, .legal_ball, .wicket_in,
    .max_balls(BALL_W'(SO_BALLS)), .max_wkts(WKT_W'(SO_WKTS)),
    .runs(so_cur), .runs_nxt(so_nxt), .wkts(so_wkts), .balls(so_balls), .limit_hit(so_lim)
  );
`endif
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state        <= S_IDLE;
      batting_team <= 1'b0;
      target       <= '0;
      winner       <= WIN_NONE;
      inning_over  <= 1'b0;
      game_over    <= 1'b0;
`ifdef SUPER_OVER_EN
      so_runs1     <= '0;
      so_runs2     <= '0;
      so_target    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_INN1;
        S_INN1: if (ball_valid && lim1) begin
          state       <= S_BREAK;
          target      <= {1'b0, r1_nxt} + (RUN_W+1)'(1);
          inning_over <= 1'b1;
        end
        S_BREAK: if (start) begin
          state        <= S_INN2;
          batting_team <= 1'b1;
          inning_over  <= 1'b0;
        end
        S_INN2: if (ball_valid) begin
          // Reaching the target wins even if the same ball also exhausts wickets or balls.
          if ({1'b0, r2_nxt} >= target || lim2) begin
            if ({1'b0, r2_nxt} >= target || r2_nxt < team1_runs) begin
              state       <= S_DONE;
              winner      <= ({1'b0, r2_nxt} >= target) ? WIN_T2 : WIN_T1;
              game_over   <= 1'b1;
              inning_over <= 1'b1;
            end else begin
`ifdef SUPER_OVER_EN
              state        <= S_SO1;
              batting_team <= 1'b0;
`else
              state       <= S_DONE;
              winner      <= WIN_TIE;
              game_over   <= 1'b1;
              inning_over <= 1'b1;
`endif
            end
          end
        end
`ifdef SUPER_OVER_EN
        S_SO1: if (ball_valid) begin
          so_runs1 <= so_nxt;
          if (so_lim) begin
            state       <= S_SO_BREAK;
            so_target   <= {1'b0, so_nxt} + (RUN_W+1)'(1);
            inning_over <= 1'b1;
          end
        end
        S_SO_BREAK: if (start) begin
          state        <= S_SO2;
          batting_team <= 1'b1;
          inning_over  <= 1'b0;
        end
        S_SO2: if (ball_valid) begin
          so_runs2 <= so_nxt;
          if ({1'b0, so_nxt} >= so_target || so_lim) begin
            state       <= S_DONE;
            winner      <= ({1'b0, so_nxt} >= so_target) ? WIN_T2 : (so_nxt < so_runs1) ? WIN_T1 : WIN_TIE;
            game_over   <= 1'b1;
            inning_over <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: vector table, directed corner sequences and random matches against a scoring model.
module tb_match_controller;
  logic clk_fpga = 1'b0;
  logic reset, start, ball_valid, legal_ball, wicket_in;
  logic [2:0] runs_in;
  logic batting_team, inning_over, game_over;
  logic [7:0] team1_runs, team2_runs;
  logic [3:0] team1_wkts, team2_wkts;
  logic [6:0] team1_balls, team2_balls;
  logic [8:0] target;
  logic [1:0] winner;
  logic s_batting_team, s_inning_over, s_game_over;
  logic [3:0] s_team1_runs, s_team2_runs;
  logic [3:0] s_team1_wkts, s_team2_wkts;
  logic [6:0] s_team1_balls, s_team2_balls;
  logic [4:0] s_target;
  logic [1:0] s_winner;
  int checks = 0;
  int errors = 0;

  match_controller dut (
    .clk_fpga(clk_fpga), .reset(reset), .start(start), .ball_valid(ball_valid), .runs_in(runs_in),
    .legal_ball(legal_ball), .wicket_in(wicket_in), .batting_team(batting_team),
    .team1_runs(team1_runs), .team2_runs(team2_runs), .team1_wkts(team1_wkts), .team2_wkts(team2_wkts),
    .team1_balls(team1_balls), .team2_balls(team2_balls), .target(target),
    .inning_over(inning_over), .game_over(game_over), .winner(winner)
  );

  // Narrow-run instance sharing the same stimulus, used to observe saturation.
  match_controller #(.RUN_W(4)) dut_sat (
    .clk_fpga(clk_fpga), .reset(reset), .start(start), .ball_valid(ball_valid), .runs_in(runs_in),
    .legal_ball(legal_ball), .wicket_in(wicket_in), .batting_team(s_batting_team),
    .team1_runs(s_team1_runs), .team2_runs(s_team2_runs), .team1_wkts(s_team1_wkts), .team2_wkts(s_team2_wkts),
    .team1_balls(s_team1_balls), .team2_balls(s_team2_balls), .target(s_target),
    .inning_over(s_inning_over), .game_over(s_game_over), .winner(s_winner)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct {int r; bit l; bit w; int er; int ew; int eb;} vec_t;
  vec_t tv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic deliver(input int r, input bit l, input bit w);
    runs_in = 3'(r);
    legal_ball = l;
    wicket_in = w;
    ball_valid = 1'b1;
    @(negedge clk_fpga);
    ball_valid = 1'b0;
    runs_in = '0;
    legal_ball = 1'b0;
    wicket_in = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_fpga);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_fpga);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bat"}, batting_team, 0);
    chk({tag, "_t1runs"}, team1_runs, 0);
    chk({tag, "_t2runs"}, team2_runs, 0);
    chk({tag, "_wkts"}, {team1_wkts, team2_wkts}, 0);
    chk({tag, "_balls"}, {team1_balls, team2_balls}, 0);
    chk({tag, "_target"}, target, 0);
    chk({tag, "_flags"}, {inning_over, game_over, winner}, 0);
  endtask

  task automatic ten_wickets();
    for (int i = 0; i < 10; i++) deliver(0, 1, 1);
  endtask

  task automatic two_innings(input int t2, input int exp_win);
    do_reset();
    pulse_start();
    for (int i = 0; i < 120; i++) deliver(i < 100 ? 1 : 0, 1, 0);
    chk("t3_target", target, 101);
    pulse_start();
    for (int i = 0; i < 119; i++) deliver(i < t2 ? 1 : 0, 1, 0);
    chk("t3_winner_before", {game_over, winner}, 0);
    deliver(0, 1, 0);
    chk("t3_winner", winner, exp_win);
    chk("t3_game_over", game_over, 1);
    chk("t3_t2balls", team2_balls, 120);
    chk("t3_t2runs", team2_runs, t2);
  endtask

  task automatic random_match();
    int r[2], w[2], b[2];
    int tgt, win, rr, n;
    bit l, wk, over;
    tgt = 0;
    win = 0;
    do_reset();
    pulse_start();
    for (int inn = 0; inn < 2; inn++) begin
      r[inn] = 0; w[inn] = 0; b[inn] = 0; over = 0; n = 0;
      while (!over && n < 2000) begin
        rr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
        l = $urandom_range(0, 9) != 0;
        wk = $urandom_range(0, 14) == 0;
        deliver(rr, l, wk);
        n++;
        r[inn] = (r[inn] + rr > 255) ? 255 : r[inn] + rr;
        w[inn] += int'(wk);
        b[inn] += int'(l);
        if (inn == 1 && r[1] > r[0]) begin
          win = 2;
          over = 1;
        end else if (w[inn] == 10 || b[inn] == 120) begin
          over = 1;
          if (inn == 0) tgt = r[0] + 1;
          else win = (r[1] < r[0]) ? 1 : 3;
        end
      end
      chk("rand_inning_end", over, 1);
      if (inn == 0) begin
        chk("rand_target", target, tgt);
        chk("rand_break", {inning_over, game_over}, 2'b10);
        pulse_start();
      end
    end
    chk("rand_t1", {team1_runs, team1_wkts, team1_balls}, {8'(r[0]), 4'(w[0]), 7'(b[0])});
    chk("rand_t2", {team2_runs, team2_wkts, team2_balls}, {8'(r[1]), 4'(w[1]), 7'(b[1])});
    chk("rand_winner", winner, win);
    chk("rand_game_over", game_over, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{4, 1, 0, 4, 0, 1};
    tv[1] = '{1, 0, 1, 5, 1, 1};
    tv[2] = '{6, 1, 0, 11, 1, 2};
    tv[3] = '{0, 0, 0, 11, 1, 2};
    tv[4] = '{7, 1, 1, 18, 2, 3};
    tv[5] = '{2, 0, 0, 20, 2, 3};
    start = 0; ball_valid = 0; runs_in = 0; legal_ball = 0; wicket_in = 0;
    @(negedge clk_fpga);
    do_reset();
    check_zero("reset");
    deliver(5, 1, 1);
    chk("idle_ball_ignored", {team1_runs, team1_wkts, team1_balls}, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      deliver(tv[i].r, tv[i].l, tv[i].w);
      chk($sformatf("vec%0d_runs", i), team1_runs, tv[i].er);
      chk($sformatf("vec%0d_wkts", i), team1_wkts, tv[i].ew);
      chk($sformatf("vec%0d_balls", i), team1_balls, tv[i].eb);
    end
    chk("vec_batting", {batting_team, inning_over}, 0);

    do_reset();
    pulse_start();
    for (int i = 0; i < 9; i++) deliver(0, 1, 1);
    chk("t1_before_end", inning_over, 0);
    deliver(0, 1, 1);
    chk("t1_wkts", team1_wkts, 10);
    chk("t1_target", target, 1);
    chk("t1_inning_over", inning_over, 1);
    deliver(4, 1, 0);
    chk("t6_break_ball", {team1_runs, team1_balls, team2_runs, team2_balls}, {8'd0, 7'd10, 8'd0, 7'd0});
    start = 1'b1;
    deliver(6, 1, 0);
    start = 1'b0;
    chk("t6_start_and_ball", {batting_team, inning_over, team2_runs, team2_balls}, {1'b1, 1'b0, 8'd0, 7'd0});
    start = 1'b1;
    deliver(0, 1, 0);
    start = 1'b0;
    chk("t6_start_mid_inning", {batting_team, inning_over, team2_balls}, {1'b1, 1'b0, 7'd1});
    deliver(1, 1, 0);
    chk("t1_chase_done", {game_over, winner}, {1'b1, 2'd2});
    start = 1'b1;
    deliver(3, 1, 1);
    start = 1'b0;
    chk("t6_done_hold", {team2_runs, team2_wkts, team2_balls, winner, game_over}, {8'd1, 4'd0, 7'd2, 2'd2, 1'b1});

    do_reset();
    pulse_start();
    for (int i = 0; i < 120; i++) begin
      deliver(1, 1, 0);
      if (i == 14) chk("t5_sat_15", s_team1_runs, 15);
      if (i == 15) chk("t5_sat_16", s_team1_runs, 15);
    end
    chk("t2_target", target, 121);
    chk("t2_t1", {team1_runs, team1_balls, inning_over}, {8'd120, 7'd120, 1'b1});
    chk("t5_sat_end", s_team1_runs, 15);
    pulse_start();
    for (int i = 0; i < 49; i++) deliver(i < 41 ? 2 : 4, 1, 0);
    chk("t2_ball49", {team2_runs, game_over, winner}, {8'd114, 1'b0, 2'd0});
    deliver(7, 1, 0);
    chk("t2_ball50", {team2_runs, team2_balls}, {8'd121, 7'd50});
    chk("t2_winner", {game_over, winner}, {1'b1, 2'd2});

    two_innings(99, 1);
    two_innings(100, 3);

    do_reset();
    pulse_start();
    ten_wickets();
    pulse_start();
    deliver(3, 1, 1);
    chk("t5_mid_inn2", {team2_runs, team2_wkts, batting_team}, {8'd3, 4'd1, 1'b1});
    reset = 1'b1;
    @(negedge clk_fpga);
    check_zero("t5_mid_reset");
    reset = 1'b0;

    for (int m = 0; m < 4; m++) random_match();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
